// File: rtl/vector_issue_controller.sv
// vector_issue_controller
// Execute-side sequencer for the vector FU: accepts one decoded op, launches
// it on the FU, waits for completion and merges the FU result into the old
// destination value under mask and vl, then offers a single writeback beat.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no op held; inst_ready follows rdy_in
// ISSUE     | op latched; pulse fu_execute once the FU is not WORKING
// WAIT_DONE | FU running; capture merged result on FINISHED seen after WORKING
// WB        | wb_valid held with stable addr/data until the handshake
module vector_issue_controller #(
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy_in,
  input  logic                            inst_valid,
  output logic                            inst_ready,
  input  logic [ENTRY_INDEX_SIZE:0]       length,
  input  logic [VECTOR_SIZE*LEN-1:0]      vs1,
  input  logic [VECTOR_SIZE*LEN-1:0]      vs2,
  input  logic [VECTOR_SIZE*LEN-1:0]      v0,
  input  logic [VECTOR_SIZE*LEN-1:0]      vd_old,
  input  logic [LEN-1:0]                  imm,
  input  logic [LEN-1:0]                  rs,
  input  logic [2:0]                      alu_signal,
  input  logic [1:0]                      vec_operand_type,
  input  logic [4:0]                      ext_type,
  input  logic [5:0]                      funct6,
  input  logic                            vm,
  input  logic [4:0]                      vd_addr,
  output logic                            fu_execute,
  output logic [ENTRY_INDEX_SIZE:0]       fu_length,
  output logic [VECTOR_SIZE*LEN-1:0]      fu_vs1,
  output logic [VECTOR_SIZE*LEN-1:0]      fu_vs2,
  output logic [VECTOR_SIZE*LEN-1:0]      fu_mask,
  output logic [LEN-1:0]                  fu_imm,
  output logic [LEN-1:0]                  fu_rs,
  output logic [2:0]                      fu_alu_signal,
  output logic [1:0]                      fu_vec_operand_type,
  output logic [4:0]                      fu_ext_type,
  output logic [5:0]                      fu_funct6,
  input  logic [VECTOR_SIZE*LEN-1:0]      fu_result,
  input  logic [1:0]                      fu_status,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [4:0]                      wb_addr,
  output logic [VECTOR_SIZE*LEN-1:0]      wb_data,
  output logic                            busy
);

  localparam logic [1:0] FU_WORKING  = 2'd1;
  localparam logic [1:0] FU_FINISHED = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_WB
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic                         seen_working;
  logic                         accept;
  logic                         capture;
  logic                         vm_q;
  logic [VECTOR_SIZE*LEN-1:0]   vd_old_q;
  logic [VECTOR_SIZE*LEN-1:0]   merged;

  // Next-state decode and the one-cycle launch strobe.
  always_comb begin
    state_nxt  = state;
    fu_execute = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (inst_valid && rdy_in) begin
          accept    = 1'b1;
          state_nxt = (length != '0) ? S_ISSUE : S_WB;
        end
      end
      S_ISSUE: begin
        if (rdy_in && (fu_status != FU_WORKING)) begin
          fu_execute = 1'b1;
          state_nxt  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // FINISHED is a single-cycle pulse, so this ignores rdy_in; a
        // FINISHED not preceded by WORKING belongs to the previous op.
        if ((fu_status == FU_FINISHED) && seen_working) begin
          capture   = 1'b1;
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        if (rdy_in && wb_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and the WORKING-observed flag for the current launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      seen_working <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fu_execute) begin
        seen_working <= 1'b0;
      end else if ((state == S_WAIT_DONE) && (fu_status == FU_WORKING)) begin
        seen_working <= 1'b1;
      end
    end
  end

  // Element merge: active, unmasked elements take the FU result; tail and
  // masked-off elements keep the old destination value.
  always_comb begin
    merged = vd_old_q;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      if ((i < int'(fu_length)) && (vm_q || fu_mask[i])) begin
        merged[i*LEN +: LEN] = fu_result[i*LEN +: LEN];
      end
    end
  end

  // Op field latches on accept and writeback data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      fu_length           <= '0;
      fu_vs1              <= '0;
      fu_vs2              <= '0;
      fu_mask             <= '0;
      fu_imm              <= '0;
      fu_rs               <= '0;
      fu_alu_signal       <= '0;
      fu_vec_operand_type <= '0;
      fu_ext_type         <= '0;
      fu_funct6           <= '0;
      vm_q                <= 1'b0;
      vd_old_q            <= '0;
      wb_addr             <= '0;
      wb_data             <= '0;
    end else begin
      if (accept) begin
        fu_length           <= length;
        fu_vs1              <= vs1;
        fu_vs2              <= vs2;
        fu_mask             <= v0;
        fu_imm              <= imm;
        fu_rs               <= rs;
        fu_alu_signal       <= alu_signal;
        fu_vec_operand_type <= vec_operand_type;
        fu_ext_type         <= ext_type;
        fu_funct6           <= funct6;
        vm_q                <= vm;
        vd_old_q            <= vd_old;
        wb_addr             <= vd_addr;
        if (length == '0) begin
          wb_data <= vd_old;
        end
      end
      if (capture) begin
        wb_data <= merged;
      end
    end
  end

  assign inst_ready = (state == S_IDLE) && rdy_in;
  assign wb_valid   = (state == S_WB);
  assign busy       = (state != S_IDLE);

endmodule
